// File: rtl/dshot_rx.sv
// dshot_rx: oversampled DShot frame receiver with CRC check and error counting
module dshot_rx #(
  parameter int CLK_HZ      = 48_000_000,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_pin,
  input  logic [1:0]  rate_sel,
  input  logic        bidir,
  input  logic        err_clr,
  output logic [10:0] value,
  output logic        telem,
  output logic        is_command,
  output logic        frame_valid,
  output logic        crc_err,
  output logic        frame_err,
  output logic        busy,
  output logic [7:0]  err_count
);
  localparam int T150  = CLK_HZ / 150_000;
  localparam int T300  = CLK_HZ / 300_000;
  localparam int T600  = CLK_HZ / 600_000;
  localparam int T1200 = CLK_HZ / 1_200_000;
  localparam int W     = $clog2(2 * T150 + 1);
  typedef enum logic [1:0] {IDLE, HIGH, LOW, DONE} state_t;
  state_t state, state_n;
  logic [SYNC_STAGES-1:0] sync;
  logic s, s_prev, rise, fall, bidir_q, start, shift, ferr, ok, good, bad;
  logic [1:0] rate_q;
  logic [W-1:0] hcnt, pcnt, th_sel, tm1_sel, t2m1_sel;
  logic [3:0] bcnt;
  logic [15:0] sh;
  logic [3:0] crc;
  assign s = sync[SYNC_STAGES-1] ^ (state == IDLE ? bidir : bidir_q);
  assign rise = s & ~s_prev;
  assign fall = ~s & s_prev;
  assign th_sel = rate_q == 2'd0 ? W'(T150 * 9 / 16) : rate_q == 2'd1 ? W'(T300 * 9 / 16) :
                  rate_q == 2'd2 ? W'(T600 * 9 / 16) : W'(T1200 * 9 / 16);
  assign tm1_sel = rate_q == 2'd0 ? W'(T150 - 1) : rate_q == 2'd1 ? W'(T300 - 1) :
                   rate_q == 2'd2 ? W'(T600 - 1) : W'(T1200 - 1);
  assign t2m1_sel = rate_q == 2'd0 ? W'(2 * T150 - 1) : rate_q == 2'd1 ? W'(2 * T300 - 1) :
                    rate_q == 2'd2 ? W'(2 * T600 - 1) : W'(2 * T1200 - 1);
  assign crc = sh[7:4] ^ sh[11:8] ^ sh[15:12];
  assign ok = sh[3:0] == (bidir_q ? ~crc : crc);
  assign good = state == DONE && ok;
  assign bad = state == DONE && !ok;
  assign busy = state != IDLE;
  // next state and per-cycle control decisions
  always_comb begin
    state_n = state;
    start = 1'b0;
    shift = 1'b0;
    ferr = 1'b0;
    case (state)
      IDLE: if (rise) begin
        state_n = HIGH;
        start = 1'b1;
      end
      HIGH: if (fall) begin
        shift = 1'b1;
        state_n = bcnt == 4'd15 ? DONE : LOW;
      end else if (hcnt == tm1_sel) begin
        ferr = 1'b1;
        state_n = IDLE;
      end
      LOW: if (rise) begin
        start = 1'b1;
        state_n = HIGH;
      end else if (pcnt == t2m1_sel) begin
        ferr = 1'b1;
        state_n = IDLE;
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else state <= state_n;
  end
  // synchronizer, pulse counters, shift register, outputs and error counter
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync <= '0;
      s_prev <= 1'b1;
      rate_q <= 2'd0;
      bidir_q <= 1'b0;
      hcnt <= '0;
      pcnt <= '0;
      bcnt <= '0;
      sh <= '0;
      value <= '0;
      telem <= 1'b0;
      is_command <= 1'b1;
      frame_valid <= 1'b0;
      crc_err <= 1'b0;
      frame_err <= 1'b0;
      err_count <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], in_pin};
      s_prev <= s;
      if (start) begin
        hcnt <= W'(1);
        pcnt <= W'(1);
      end else begin
        if (state == HIGH) hcnt <= hcnt + W'(1);
        if (state == HIGH || state == LOW) pcnt <= pcnt + W'(1);
      end
      if (start && state == IDLE) begin
        bcnt <= '0;
        sh <= '0;
        rate_q <= rate_sel;
        bidir_q <= bidir;
      end
      if (shift) begin
        sh <= {sh[14:0], hcnt >= th_sel};
        bcnt <= bcnt + 4'd1;
      end
      if (good) begin
        value <= sh[15:5];
        telem <= sh[4];
        is_command <= sh[15:5] < 11'd48;
      end
      frame_valid <= good;
      crc_err <= bad;
      frame_err <= ferr;
      err_count <= err_clr ? 8'd0 : ((ferr || bad) && err_count != 8'hff) ? err_count + 8'd1 : err_count;
    end
  end
endmodule

// File: tb/tb_dshot_rx.sv
// tb_dshot_rx: table-driven and scoreboard check of the DShot receiver
`timescale 1ns/1ps
module tb_dshot_rx;
  localparam int SYNC = 2;
  logic clk = 1'b0, reset_n, in_pin, bidir, err_clr;
  logic [1:0] rate_sel;
  logic [10:0] value;
  logic telem, is_command, frame_valid, crc_err, frame_err, busy;
  logic [7:0] err_count;
  int cyc = 0;
  int n_chk = 0, n_fail = 0;
  typedef struct {
    logic [2:0] str;
    int cyc;
    logic [10:0] val;
    logic tel;
    logic cmd;
    logic [7:0] ec;
  } exp_t;
  exp_t sbq[$];
  typedef struct {
    logic [15:0] frame;
    logic [1:0] rate;
    logic bid;
    int hi1, hi0, sb, sbhi, sbper;
    logic [2:0] str;
    logic [10:0] val;
    logic tel, cmd;
  } vec_t;
  vec_t vt[9];
  logic [10:0] m_val;
  logic m_tel, m_cmd;
  logic [7:0] m_ec;
  dshot_rx #(.CLK_HZ(48_000_000), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .reset_n(reset_n), .in_pin(in_pin), .rate_sel(rate_sel), .bidir(bidir),
    .err_clr(err_clr), .value(value), .telem(telem), .is_command(is_command),
    .frame_valid(frame_valid), .crc_err(crc_err), .frame_err(frame_err), .busy(busy),
    .err_count(err_count)
  );
  always #10 clk = ~clk;
  // edge counter used for latency checks
  always @(posedge clk) cyc <= cyc + 1;
  function automatic int tper(input logic [1:0] r);
    return r == 2'd0 ? 320 : r == 2'd1 ? 160 : r == 2'd2 ? 80 : 40;
  endfunction
  task automatic check(input string name, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic expect_ev(input logic [2:0] str, input int c, input logic clr);
    if (str != 3'b001) m_ec = clr ? 8'd0 : (m_ec == 8'hff ? 8'hff : m_ec + 8'd1);
    sbq.push_back('{str, c, m_val, m_tel, m_cmd, m_ec});
  endtask
  task automatic send_bits(input logic [15:0] frame, input int n, input int hi1, input int hi0,
                           input int per, input int sb, input int sbhi, input int sbper,
                           input logic [2:0] str, output int lr);
    int h, p;
    for (int i = 0; i < n; i++) begin
      h = (i == sb && sbhi > 0) ? sbhi : (frame[15-i] ? hi1 : hi0);
      p = (i == sb && sbper > 0) ? sbper : per;
      in_pin = ~bidir;
      lr = cyc;
      tick(h);
      in_pin = bidir;
      if (i == n - 1 && str != 3'b000) expect_ev(str, cyc + SYNC + 2, 1'b0);
      tick(p - h);
    end
  endtask
  task automatic do_reset();
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    check("rst_value", value, 0);
    check("rst_telem", telem, 0);
    check("rst_is_command", is_command, 1);
    check("rst_busy", busy, 0);
    check("rst_err_count", err_count, 0);
    check("rst_strobes", {frame_err, crc_err, frame_valid}, 0);
    m_val = 0;
    m_tel = 0;
    m_cmd = 1;
    m_ec = 0;
    tick(SYNC + 2);
  endtask
  task automatic stop_after(input int n, input logic [1:0] r, input logic clr);
    int lr, c;
    rate_sel = r;
    tick(3);
    send_bits(16'h82C6, n, tper(r) * 3 / 4, tper(r) * 3 / 8, tper(r), -1, 0, 0, 3'b000, lr);
    c = lr + 2 * tper(r) + SYNC;
    expect_ev(3'b100, c, clr);
    tick(c - 1 - cyc);
    err_clr = clr;
    tick(1);
    err_clr = 1'b0;
    tick(4);
  endtask
  // scoreboard: every strobe is matched against the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (frame_valid || crc_err || frame_err) begin
      if (sbq.size() == 0) check("unexpected_strobe", {frame_err, crc_err, frame_valid}, 0);
      else begin
        e = sbq.pop_front();
        check("strobe_kind", {frame_err, crc_err, frame_valid}, e.str);
        check("strobe_cycle", cyc, e.cyc);
        check("value", value, e.val);
        check("telem", telem, e.tel);
        check("is_command", is_command, e.cmd);
        check("err_count", err_count, e.ec);
      end
    end
  end
  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    int lr;
    vt[0] = '{16'h82C6, 2'd2, 1'b0, 60, 30, -1, 0, 0, 3'b001, 11'd1046, 1'b0, 1'b0};
    vt[1] = '{16'h82C9, 2'd2, 1'b1, 60, 30, -1, 0, 0, 3'b001, 11'd1046, 1'b0, 1'b0};
    vt[2] = '{16'h82C6, 2'd2, 1'b1, 60, 30, -1, 0, 0, 3'b010, 11'd0, 1'b0, 1'b0};
    vt[3] = '{16'h00BB, 2'd0, 1'b0, 240, 120, -1, 0, 0, 3'b001, 11'd5, 1'b1, 1'b1};
    vt[4] = '{16'h00BB, 2'd3, 1'b0, 30, 15, -1, 0, 0, 3'b001, 11'd5, 1'b1, 1'b1};
    vt[5] = '{16'h82C6, 2'd2, 1'b0, 60, 30, 0, 45, 0, 3'b001, 11'd1046, 1'b0, 1'b0};
    vt[6] = '{16'h82C6, 2'd2, 1'b0, 60, 30, 0, 44, 0, 3'b010, 11'd0, 1'b0, 1'b0};
    vt[7] = '{16'h82C6, 2'd2, 1'b0, 60, 30, 15, 45, 0, 3'b010, 11'd0, 1'b0, 1'b0};
    vt[8] = '{16'h82C6, 2'd2, 1'b0, 60, 30, 3, 0, 159, 3'b001, 11'd1046, 1'b0, 1'b0};
    reset_n = 1'b0;
    in_pin = 1'b0;
    bidir = 1'b0;
    rate_sel = 2'd2;
    err_clr = 1'b0;
    tick(3);
    do_reset();
    for (int i = 0; i < 9; i++) begin
      if (vt[i].bid != bidir) begin
        bidir = vt[i].bid;
        in_pin = vt[i].bid;
        do_reset();
      end
      rate_sel = vt[i].rate;
      tick(5);
      if (vt[i].str == 3'b001) begin
        m_val = vt[i].val;
        m_tel = vt[i].tel;
        m_cmd = vt[i].cmd;
      end
      send_bits(vt[i].frame, 16, vt[i].hi1, vt[i].hi0, tper(vt[i].rate), vt[i].sb, vt[i].sbhi,
                vt[i].sbper, vt[i].str, lr);
      tick(20);
      check("busy_after_frame", busy, 0);
    end
    rate_sel = 2'd2;
    tick(3);
    in_pin = 1'b1;
    expect_ev(3'b100, cyc + 80 + SYNC, 1'b0);
    tick(80);
    in_pin = 1'b0;
    tick(6);
    check("busy_after_long_high", busy, 0);
    stop_after(7, 2'd2, 1'b0);
    for (int i = 0; i < 299; i++) stop_after(1, 2'd3, 1'b0);
    check("err_count_saturated", err_count, 255);
    stop_after(1, 2'd3, 1'b1);
    check("err_count_cleared", err_count, 0);
    rate_sel = 2'd2;
    tick(3);
    send_bits(16'h82C6, 5, 60, 30, 80, -1, 0, 0, 3'b000, lr);
    check("busy_mid_frame", busy, 1);
    do_reset();
    m_val = 11'd5;
    m_tel = 1'b1;
    m_cmd = 1'b1;
    send_bits(16'h00BB, 16, 60, 30, 80, -1, 0, 0, 3'b001, lr);
    tick(20);
    check("scoreboard_drained", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
